// File: rtl/r_channel.sv
// OBI R-channel response generator: tracks accepted A-channel transactions and returns
// controller results in order. Optional macro R_CHANNEL_RREADY_EN enables rready back-pressure.
module r_channel #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_accept,
    input  logic                  a_we,
    input  logic                  ctrl_done,
    input  logic [DATA_WIDTH-1:0] ctrl_rdata,
    input  logic                  ctrl_err,
    input  logic                  rready,
    output logic                  internal_gnt,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  protocol_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [DEPTH-1:0]    type_mem_q;
    ptr_t                type_wptr_q, type_wptr_d;
    ptr_t                type_rptr_q, type_rptr_d;
    cnt_t                type_cnt_q,  type_cnt_d;

    logic [DATA_WIDTH:0] resp_mem_q [DEPTH];
    ptr_t                resp_wptr_q, resp_wptr_d;
    ptr_t                resp_rptr_q, resp_rptr_d;
    cnt_t                resp_cnt_q,  resp_cnt_d;

    cnt_t                out_cnt_q,   out_cnt_d;
    logic                perr_q,      perr_d;

    logic                acc;
    logic                done_ok;
    logic                rready_eff;
    logic                pop;
    logic                type_head;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [DATA_WIDTH:0] resp_head;

`ifdef R_CHANNEL_RREADY_EN
    assign rready_eff = rready;
`else
    logic unused_rready;
    assign unused_rready = rready;
    assign rready_eff    = 1'b1;
`endif

    assign internal_gnt = (out_cnt_q < cnt_t'(DEPTH));
    assign rvalid       = (resp_cnt_q != '0);
    assign resp_head    = resp_mem_q[resp_rptr_q];
    assign rdata        = rvalid ? resp_head[DATA_WIDTH:1] : '0;
    assign err          = rvalid ? resp_head[0] : 1'b0;
    assign protocol_err = perr_q;

    // Accepts beyond the grant are upstream violations and are dropped here.
    assign acc       = a_accept & internal_gnt;
    assign done_ok   = ctrl_done & (type_cnt_q != '0);
    assign pop       = rvalid & rready_eff;
    assign type_head = type_mem_q[type_rptr_q];
    assign resp_data = type_head ? '0 : ctrl_rdata;

    always_comb begin
        type_wptr_d = type_wptr_q;
        type_rptr_d = type_rptr_q;
        type_cnt_d  = type_cnt_q;
        if (acc) begin
            type_wptr_d = ptr_inc(type_wptr_q);
        end
        if (done_ok) begin
            type_rptr_d = ptr_inc(type_rptr_q);
        end
        case ({acc, done_ok})
            2'b10:   type_cnt_d = type_cnt_q + cnt_t'(1);
            2'b01:   type_cnt_d = type_cnt_q - cnt_t'(1);
            default: type_cnt_d = type_cnt_q;
        endcase
    end

    always_comb begin
        resp_wptr_d = resp_wptr_q;
        resp_rptr_d = resp_rptr_q;
        resp_cnt_d  = resp_cnt_q;
        if (done_ok) begin
            resp_wptr_d = ptr_inc(resp_wptr_q);
        end
        if (pop) begin
            resp_rptr_d = ptr_inc(resp_rptr_q);
        end
        case ({done_ok, pop})
            2'b10:   resp_cnt_d = resp_cnt_q + cnt_t'(1);
            2'b01:   resp_cnt_d = resp_cnt_q - cnt_t'(1);
            default: resp_cnt_d = resp_cnt_q;
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({acc, pop})
            2'b10:   out_cnt_d = out_cnt_q + cnt_t'(1);
            2'b01:   out_cnt_d = out_cnt_q - cnt_t'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        perr_d = perr_q | (ctrl_done & (type_cnt_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_wptr_q <= '0;
            type_rptr_q <= '0;
            type_cnt_q  <= '0;
            resp_wptr_q <= '0;
            resp_rptr_q <= '0;
            resp_cnt_q  <= '0;
            out_cnt_q   <= '0;
            perr_q      <= 1'b0;
        end else begin
            type_wptr_q <= type_wptr_d;
            type_rptr_q <= type_rptr_d;
            type_cnt_q  <= type_cnt_d;
            resp_wptr_q <= resp_wptr_d;
            resp_rptr_q <= resp_rptr_d;
            resp_cnt_q  <= resp_cnt_d;
            out_cnt_q   <= out_cnt_d;
            perr_q      <= perr_d;
        end
    end

    // Storage arrays need no reset: entries are only read while their count is non-zero.
    always_ff @(posedge clk) begin
        if (acc) begin
            type_mem_q[type_wptr_q] <= a_we;
        end
        if (done_ok) begin
            resp_mem_q[resp_wptr_q] <= {resp_data, ctrl_err};
        end
    end

endmodule

// File: tb/tb_r_channel.sv
// Self-checking bench for r_channel: directed scenarios then random traffic, all
// compared each cycle against a queue-based reference model.
module tb_r_channel;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
`ifdef R_CHANNEL_RREADY_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_accept = 1'b0;
    logic          a_we = 1'b0;
    logic          ctrl_done = 1'b0;
    logic [DW-1:0] ctrl_rdata = '0;
    logic          ctrl_err = 1'b0;
    logic          rready = 1'b0;
    logic          internal_gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic          protocol_err;

    r_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_accept     (a_accept),
        .a_we         (a_we),
        .ctrl_done    (ctrl_done),
        .ctrl_rdata   (ctrl_rdata),
        .ctrl_err     (ctrl_err),
        .rready       (rready),
        .internal_gnt (internal_gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .err          (err),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          e;
    } resp_t;

    // Reference model: pending operation types, queued responses, outstanding total.
    bit    m_type[$];
    resp_t m_resp[$];
    int    m_out;
    bit    m_perr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_type.delete();
        m_resp.delete();
        m_out  = 0;
        m_perr = 0;
    endtask

    task automatic check_outputs();
        bit            ev;
        logic [DW-1:0] ed;
        bit            ee;
        ev = (m_resp.size() > 0);
        ed = ev ? m_resp[0].data : '0;
        ee = ev ? m_resp[0].e : 1'b0;
        check("internal_gnt", 64'(internal_gnt), 64'(m_out < DEPTH));
        check("rvalid", 64'(rvalid), 64'(ev));
        check("rdata", 64'(rdata), 64'(ed));
        check("err", 64'(err), 64'(ee));
        check("protocol_err", 64'(protocol_err), 64'(m_perr));
    endtask

    // Called at a negedge: check current outputs, drive inputs, advance model, run one cycle.
    task automatic step(input bit acc, input bit we, input bit done,
                        input logic [DW-1:0] d, input bit e, input bit rr);
        bit    gnt, pop, acc_ok;
        resp_t r;
        check_outputs();
        a_accept   = acc;
        a_we       = we;
        ctrl_done  = done;
        ctrl_rdata = d;
        ctrl_err   = e;
        rready     = rr;
        gnt    = (m_out < DEPTH);
        acc_ok = acc && gnt;
        pop    = (m_resp.size() > 0) && (rr || !RR_EN);
        if (pop) void'(m_resp.pop_front());
        if (done) begin
            if (m_type.size() == 0) begin
                m_perr = 1;
            end else begin
                r.data = m_type.pop_front() ? '0 : d;
                r.e    = e;
                m_resp.push_back(r);
            end
        end
        if (acc_ok) m_type.push_back(we);
        m_out = m_out + int'(acc_ok) - int'(pop);
        @(posedge clk);
        @(negedge clk);
        a_accept  = 1'b0;
        ctrl_done = 1'b0;
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 0, '0, 0, rr);
    endtask

    task automatic drain();
        int budget = 50;
        while ((m_type.size() > 0 || m_resp.size() > 0) && budget > 0) begin
            if (m_type.size() > 0) step(0, 0, 1, $urandom, 0, 1);
            else                   idle(1);
            budget--;
        end
        check("drain_timeout", 64'(budget > 0), 64'(1));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_gnt", 64'(internal_gnt), 64'(1));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_perr", 64'(protocol_err), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Read transaction
        step(1, 0, 0, '0, 0, 1);
        idle(1);
        step(0, 0, 1, 32'hDEADBEEF, 0, 1);
        check("read_rvalid", 64'(rvalid), 64'(1));
        check("read_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        idle(1);
        check("read_done_gnt", 64'(internal_gnt), 64'(1));
        check("read_done_rvalid", 64'(rvalid), 64'(0));

        // Write transaction: data forced to zero
        step(1, 1, 0, '0, 0, 1);
        step(0, 0, 1, 32'h12345678, 1, 1);
        check("write_rdata", 64'(rdata), 64'(0));
        check("write_err", 64'(err), 64'(1));
        idle(1);

        // Fill, back-pressure, then release
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        check("full_gnt", 64'(internal_gnt), 64'(0));
        step(1, 0, 1, 32'h11, 0, 0);
        step(0, 0, 1, 32'h22, 0, 0);
        for (int i = 0; i < 5; i++) idle(0);
        idle(1);
        idle(1);
        drain();

        // Simultaneous pop and accept at outstanding == DEPTH
        step(1, 0, 0, '0, 0, 0);
        step(1, 1, 1, 32'h33, 0, 0);
        idle(0);
        step(1, 0, 0, '0, 0, 1);
        idle(0);
        drain();

        // Spurious completion
        step(0, 0, 1, 32'hBAD, 1, 1);
        check("spurious_rvalid", 64'(rvalid), 64'(0));
        check("spurious_perr", 64'(protocol_err), 64'(1));
        idle(1);

        // Reset with responses pending
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 1, 32'h44, 0, 0);
        step(0, 0, 1, 32'h55, 0, 0);
        async_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 50), $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 40), $urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 60));
            if ($urandom_range(0, 999) == 0) async_reset();
        end
        drain();
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
